demux1to4_32_buf: RTL and testbench
===================================

Name: demux1to4_32_buf

Overview:
- Registered 1-to-4 distributor for 32-bit words: the inverse of the 4-to-1 datapath select.
- Accepts one word per cycle with a 2-bit destination select and steers it into one of four independent output channels.
- Each channel has a 2-entry buffer and a valid/ready handshake.
- Used to fan a single producer (e.g. writeback/result bus) out to four consumers without combinational ready paths back through the select.

Parameters:
- WIDTH, 32, data word width.
- DEPTH, 2, entries per channel buffer. Fixed at 2 in this revision; other values are unsupported.
- CNT_W, 16, width of each per-channel delivered-word counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  producer has a word.
- in_sel  input  2  destination channel 0..3; must be stable while in_valid=1 and in_ready=0.
- in_data  input  WIDTH  word to steer.
- in_ready  output  1  selected channel can accept.
- out_valid  output  4  per-channel word available; bit k is channel k.
- out_ready  input  4  per-channel consumer accept.
- out_data  output  4*WIDTH  channel k on bits [k*WIDTH +: WIDTH].
- out_cnt  output  4*CNT_W  per-channel count of delivered words (out_valid&out_ready), saturating.
- busy  output  1  OR of out_valid.

Behaviour:
- Reset (rst=1 at a rising edge): all buffers empty, out_valid=0, out_data=0, out_cnt=0, busy=0. in_ready reads 1 combinationally once reset is released.
- Reset mid-operation discards all buffered words; it takes precedence over any push or pop in the same cycle.
- Input accept: push to channel in_sel on an edge where in_valid=1 and in_ready=1.
- in_ready = NOT full[in_sel]. It depends only on in_sel and registered state, never on out_ready, so there is no combinational ready path.
- Latency: a word accepted at edge N appears at out_valid/out_data of its channel in the cycle after edge N (1 cycle). No pass-through bypass.
- Channel buffer: 2-entry FIFO per channel with head/tail pointers and a 2-bit count (0..2).
  - full = (count==2); empty = (count==0).
  - out_valid[k] = NOT empty[k]; out_data[k] = head entry, registered storage only.
- Pop: on an edge where out_valid[k]=1 and out_ready[k]=1, advance head and decrement count.
  - out_ready[k] while empty has no effect.
- Simultaneous push and pop on the same channel: count is unchanged and the data order is preserved.
  - When count==1, the popped word is the old head and the pushed word becomes the new head.
  - A push into a full channel cannot occur, because in_ready=0. A pop in that cycle frees a slot visible on the next cycle only.
- Channels are independent: one channel may be full while the producer sends to others at full rate.
- in_valid=0: in_sel and in_data are ignored.
- Order: within a channel, strict FIFO. Across channels, no ordering is implied.
- out_cnt[k] increments by 1 on each pop of channel k and saturates at 2^CNT_W-1 (no wrap).
- busy = |out_valid, registered-derived.
- Throughput: one push per cycle and one pop per channel per cycle, sustained when consumers are always ready.

Decomposition:
- Shared package: WIDTH and CNT_W defaults, and channel-index constants CH0..CH3 = 2'd0..2'd3 (matching the select encoding of the 4-to-1 mux).
- Sub-module chan_fifo2: a 2-entry WIDTH-bit FIFO with push/pop/full/empty/head, instantiated 4 times under a generate loop.
- The top level holds the select decode, the in_ready mux, and the counters.

Test Plan:
- Reset check: assert rst for 2 cycles with in_valid=1, then release -> out_valid=0000, out_cnt all 0, in_ready=1, and no word is captured during reset.
- Single route: in_sel=2, in_data=32'hDEADBEEF, one cycle, out_ready=0000 -> next cycle out_valid=0100 and channel 2 data=DEADBEEF; after out_ready[2]=1 for one edge, out_valid=0000 and out_cnt[2]=1.
- Backpressure/full: three pushes to channel 1 (values 1,2,3) with out_ready=0000 -> in_ready=0 on the third push, so only words 1 and 2 are stored. Then out_ready[1]=1 -> in_ready=1 next cycle, word 3 is accepted, and the pop order is 1,2,3.
- Simultaneous push/pop: channel 0 holds A, push B while popping -> count stays 1, out_data ch0=B next cycle. With count 2 holding A,B, pop while pushing to ch3 -> ch0 holds B and ch3 holds the new word.
- Round robin at full rate: sel 0,1,2,3 repeated for 16 cycles with out_ready=1111 -> in_ready constantly 1, each channel delivers 4 words in order, and out_cnt = 4,4,4,4.
- Saturation and mid-op reset: with CNT_W=4, deliver 20 words to channel 3 -> out_cnt[3]=15. Then assert rst while channels hold data -> all buffers empty and counters 0 the next cycle.

Source files
------------

// File: rtl/demux1to4_32_buf_pkg.sv
// Shared defaults and channel-index encoding for the 1-to-4 buffered distributor.
package demux1to4_32_buf_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned DEPTH_DEF = 2;
  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned NUM_CH    = 4;

  // Channel indices, same encoding as the select of the 4-to-1 mux.
  typedef enum logic [1:0] {
    CH0 = 2'd0,
    CH1 = 2'd1,
    CH2 = 2'd2,
    CH3 = 2'd3
  } chan_e;

endpackage

// File: rtl/demux1to4_32_buf_chan_fifo2.sv
// Two-entry FIFO used as the per-channel output buffer; head is registered storage.
module chan_fifo2 #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             hd_ptr;
  logic             tl_ptr;
  logic [1:0]       count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == 2'(DEPTH));
  assign empty   = (count == 2'd0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[hd_ptr];

  // Storage, pointers and occupancy; a simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      hd_ptr <= 1'b0;
      tl_ptr <= 1'b0;
      count  <= 2'd0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[tl_ptr] <= din;
        tl_ptr      <= ~tl_ptr;
      end
      if (do_pop) begin
        hd_ptr <= ~hd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/demux1to4_32_buf.sv
// Registered 1-to-4 distributor: steers one word per cycle into one of four
// 2-entry channel buffers; in_ready depends only on in_sel and registered state.
module demux1to4_32_buf
  import demux1to4_32_buf_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [1:0]           in_sel,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_ready,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready,
  output logic [4*WIDTH-1:0]   out_data,
  output logic [4*CNT_W-1:0]   out_cnt,
  output logic                 busy
);

  chan_e            sel_ch;
  logic             accept;
  logic [3:0]       full;
  logic [3:0]       empty;
  logic [3:0]       push;
  logic [3:0]       pop;
  logic [CNT_W-1:0] cnt [NUM_CH];

  assign sel_ch    = chan_e'(in_sel);
  assign in_ready  = ~full[sel_ch];
  assign accept    = in_valid & in_ready;
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign busy      = |out_valid;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    assign push[k] = accept & (sel_ch == chan_e'(k));

    chan_fifo2 #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[k]),
      .pop   (pop[k]),
      .din   (in_data),
      .full  (full[k]),
      .empty (empty[k]),
      .head  (out_data[k*WIDTH +: WIDTH])
    );

    // Delivered-word counter, saturating at all-ones.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt[k] <= '0;
      end else if (pop[k] && (cnt[k] != '1)) begin
        cnt[k] <= cnt[k] + 1'b1;
      end
    end

    assign out_cnt[k*CNT_W +: CNT_W] = cnt[k];
  end

endmodule

// File: tb/tb_demux1to4_32_buf.sv
// Self-checking bench: per-channel queue model plus directed literal checks.
module tb_demux1to4_32_buf;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [1:0]      in_sel;
  logic [W-1:0]    in_data;
  logic            in_ready;
  logic [3:0]      out_valid;
  logic [3:0]      out_ready;
  logic [4*W-1:0]  out_data;
  logic [4*CW-1:0] out_cnt;
  logic            busy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [W-1:0] mq [4][$];
  int unsigned  mcnt [4];
  bit           stall = 1'b0;

  demux1to4_32_buf #(
    .WIDTH (W),
    .DEPTH (2),
    .CNT_W (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ch_data(input int k);
    return out_data[k*W +: W];
  endfunction

  function automatic logic [CW-1:0] ch_cnt(input int k);
    return out_cnt[k*CW +: CW];
  endfunction

  // Reference model: one queue per channel, updated at every rising edge.
  always @(posedge clk) begin
    bit rdy;
    bit acc;
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        mq[k].delete();
        mcnt[k] = 0;
      end
      stall = 1'b0;
    end else begin
      rdy = (mq[in_sel].size() < 2);
      acc = in_valid && rdy;
      for (int k = 0; k < 4; k++) begin
        if (mq[k].size() > 0 && out_ready[k]) begin
          void'(mq[k].pop_front());
          if (mcnt[k] < CMAX) mcnt[k]++;
        end
      end
      if (acc) mq[in_sel].push_back(in_data);
      stall = in_valid && !acc;
    end
  end

  // Compare process: outputs against the model every cycle, after inputs settle.
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("model_valid%0d", k), 64'(out_valid[k]), 64'(mq[k].size() > 0));
        if (mq[k].size() > 0)
          chk($sformatf("model_data%0d", k), 64'(ch_data(k)), 64'(mq[k][0]));
        chk($sformatf("model_cnt%0d", k), 64'(ch_cnt(k)), 64'(mcnt[k]));
      end
      chk("model_in_ready", 64'(in_ready), 64'(mq[in_sel].size() < 2));
      chk("model_busy", 64'(busy), 64'(out_valid != 4'b0000));
    end
  end

  task automatic drive(input bit r, input bit v, input logic [1:0] s,
                       input logic [W-1:0] d, input logic [3:0] ordy);
    @(negedge clk);
    rst       = r;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = ordy;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 2'd0, '0, 4'b0000);
    drive(1'b0, 1'b0, 2'd0, '0, 4'b0000);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = 4'b0000;

    // Reset held two cycles with in_valid=1: nothing may be captured.
    drive(1'b1, 1'b1, 2'd1, 32'h1234_5678, 4'b0000);
    drive(1'b1, 1'b1, 2'd1, 32'h1234_5678, 4'b0000);
    drive(1'b0, 1'b0, 2'd0, '0, 4'b0000);
    chk_en = 1'b1;
    #1;
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_cnt", 64'(out_cnt), 64'h0);
    chk("rst_ready", 64'(in_ready), 64'h1);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_data", 64'(out_data[63:0]), 64'h0);

    // Single route to channel 2.
    drive(1'b0, 1'b1, 2'd2, 32'hDEADBEEF, 4'b0000);
    drive(1'b0, 1'b0, 2'd0, '0, 4'b0100);
    #1;
    chk("route_valid", 64'(out_valid), 64'h4);
    chk("route_data", 64'(ch_data(2)), 64'hDEADBEEF);
    drive(1'b0, 1'b0, 2'd0, '0, 4'b0000);
    #1;
    chk("route_valid_after", 64'(out_valid), 64'h0);
    chk("route_cnt2", 64'(ch_cnt(2)), 64'h1);

    // Backpressure on channel 1.
    do_reset();
    drive(1'b0, 1'b1, 2'd1, 32'd1, 4'b0000);
    drive(1'b0, 1'b1, 2'd1, 32'd2, 4'b0000);
    drive(1'b0, 1'b1, 2'd1, 32'd3, 4'b0000);
    #1;
    chk("bp_ready_full", 64'(in_ready), 64'h0);
    drive(1'b0, 1'b1, 2'd1, 32'd3, 4'b0010);
    #1;
    chk("bp_ready_same_cycle", 64'(in_ready), 64'h0);
    chk("bp_pop1", 64'(ch_data(1)), 64'd1);
    drive(1'b0, 1'b1, 2'd1, 32'd3, 4'b0010);
    #1;
    chk("bp_ready_freed", 64'(in_ready), 64'h1);
    chk("bp_pop2", 64'(ch_data(1)), 64'd2);
    drive(1'b0, 1'b0, 2'd0, '0, 4'b0010);
    #1;
    chk("bp_pop3", 64'(ch_data(1)), 64'd3);
    drive(1'b0, 1'b0, 2'd0, '0, 4'b0000);
    #1;
    chk("bp_empty", 64'(out_valid), 64'h0);
    chk("bp_cnt1", 64'(ch_cnt(1)), 64'd3);

    // Simultaneous push/pop on channel 0.
    do_reset();
    drive(1'b0, 1'b1, 2'd0, 32'hAAAA_0001, 4'b0000);
    drive(1'b0, 1'b1, 2'd0, 32'hBBBB_0002, 4'b0001);
    #1;
    chk("pp_head_a", 64'(ch_data(0)), 64'hAAAA_0001);
    drive(1'b0, 1'b1, 2'd0, 32'hCCCC_0003, 4'b0000);
    #1;
    chk("pp_head_b", 64'(ch_data(0)), 64'hBBBB_0002);
    chk("pp_valid_b", 64'(out_valid), 64'h1);
    drive(1'b0, 1'b1, 2'd3, 32'hDDDD_0004, 4'b0001);
    drive(1'b0, 1'b0, 2'd0, '0, 4'b0000);
    #1;
    chk("pp_head_c", 64'(ch_data(0)), 64'hCCCC_0003);
    chk("pp_ch3", 64'(ch_data(3)), 64'hDDDD_0004);
    chk("pp_valid", 64'(out_valid), 64'h9);

    // Round robin at full rate.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 2'(i % 4), $urandom, 4'b1111);
      #1;
      chk("rr_ready", 64'(in_ready), 64'h1);
    end
    drive(1'b0, 1'b0, 2'd0, '0, 4'b1111);
    drive(1'b0, 1'b0, 2'd0, '0, 4'b1111);
    #1;
    chk("rr_cnt", 64'(out_cnt), 64'h4444);

    // Saturation on channel 3.
    do_reset();
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 2'd3, 32'(i), 4'b1000);
    drive(1'b0, 1'b0, 2'd0, '0, 4'b1000);
    drive(1'b0, 1'b0, 2'd0, '0, 4'b1000);
    #1;
    chk("sat_cnt3", 64'(ch_cnt(3)), 64'd15);

    // Reset while channels hold data, overriding a push and pops.
    drive(1'b0, 1'b1, 2'd0, 32'h11, 4'b0000);
    drive(1'b0, 1'b1, 2'd1, 32'h22, 4'b0000);
    drive(1'b1, 1'b1, 2'd2, 32'h33, 4'b1111);
    drive(1'b0, 1'b0, 2'd0, '0, 4'b0000);
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'h0);
    chk("mid_rst_cnt", 64'(out_cnt), 64'h0);
    chk("mid_rst_busy", 64'(busy), 64'h0);

    // Random traffic; in_sel/in_data held while a word is stalled.
    for (int i = 0; i < 3000; i++) begin
      if (stall)
        drive(($urandom_range(0, 299) == 0), 1'b1, in_sel, in_data, 4'($urandom));
      else
        drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0),
              2'($urandom), $urandom, 4'($urandom));
    end
    drive(1'b0, 1'b0, 2'd0, '0, 4'b0000);
    @(negedge clk);
    #3;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
